// File: rtl/ldtu_sample_packer.sv
// ldtu_sample_packer
// Packs the LiTe-DTU sample stream into 32-bit words and buffers them in a
// small circular FIFO towards the serializer/consumer.
//   - Baseline samples keep only DATA_to_enc[5:0]; five of them fill a word,
//     fewer are flushed as a partial word carrying a 4-bit count.
//   - Signal samples keep all 13 bits; two fill a word, one alone is flushed
//     as a single-sample word.
// Ports:
//   CLK           : clock, everything on its rising edge
//   reset         : asynchronous active-low reset
//   enable        : packing enable, one sample consumed per cycle while high
//   DATA_to_enc   : 13-bit input sample (bit 12 = gain flag)
//   baseline_flag : 1 = baseline sample, 0 = signal sample
//   out_data      : head word of the buffer, 0 when the buffer is empty
//   out_valid     : buffer not empty
//   out_ready     : consumer pops the head word when out_valid is high
//   fifo_level    : number of words held in the buffer
//   overflow      : sticky flag, a word was dropped because the buffer was full
module ldtu_sample_packer #(
  parameter int FifoDepth = 8,
  parameter int NBitsCnt  = 3
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                enable,
  input  logic [12:0]         DATA_to_enc,
  input  logic                baseline_flag,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NBitsCnt:0]   fifo_level,
  output logic                overflow
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    BASE_ACC = 2'd1,
    SIG_ACC  = 2'd2
  } state_t;

  localparam logic [NBitsCnt-1:0] PtrOne = 1;
  localparam logic [NBitsCnt:0]   LvlOne = 1;

  state_t              state;
  state_t              state_next;
  logic [2:0]          cnt;
  logic [2:0]          cnt_next;
  logic [23:0]         base_acc;
  logic [12:0]         sig_acc;
  logic                push_req;
  logic [31:0]         push_word;
  logic [31:0]         partial_word;

  logic [31:0]         mem [FifoDepth];
  logic [NBitsCnt-1:0] wr_ptr;
  logic [NBitsCnt-1:0] rd_ptr;
  logic                full;
  logic                pop;
  logic                push_ok;

  // State register and sample counter.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: a group closes when it is full, when the sample type
  // changes (the new sample immediately opens the opposite group) or when
  // enable drops.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (enable) begin
      case (state)
        EMPTY: begin
          state_next = baseline_flag ? BASE_ACC : SIG_ACC;
          cnt_next   = 3'd1;
        end
        BASE_ACC: begin
          if (baseline_flag) begin
            if (cnt == 3'd4) begin
              state_next = EMPTY;
              cnt_next   = 3'd0;
            end else begin
              cnt_next = cnt + 3'd1;
            end
          end else begin
            state_next = SIG_ACC;
            cnt_next   = 3'd1;
          end
        end
        SIG_ACC: begin
          if (!baseline_flag) begin
            state_next = EMPTY;
            cnt_next   = 3'd0;
          end else begin
            state_next = BASE_ACC;
            cnt_next   = 3'd1;
          end
        end
        default: begin
          state_next = EMPTY;
          cnt_next   = 3'd0;
        end
      endcase
    end else if (state != EMPTY) begin
      state_next = EMPTY;
      cnt_next   = 3'd0;
    end
  end

  // Output logic: decides whether a word is pushed this edge and builds it.
  // Unused baseline fields are zero because base_acc is cleared when a new
  // baseline group opens.
  always_comb begin
    partial_word = (state == BASE_ACC) ? {4'b1110, 1'b0, cnt, base_acc}
                                       : {6'b001011, 13'b0, sig_acc};
    push_req  = 1'b0;
    push_word = 32'h0;
    if (state != EMPTY) begin
      if (!enable) begin
        push_req  = 1'b1;
        push_word = partial_word;
      end else if (state == BASE_ACC) begin
        if (!baseline_flag) begin
          push_req  = 1'b1;
          push_word = partial_word;
        end else if (cnt == 3'd4) begin
          push_req  = 1'b1;
          push_word = {2'b01, DATA_to_enc[5:0], base_acc};
        end
      end else begin
        push_req  = 1'b1;
        push_word = baseline_flag ? partial_word
                                  : {6'b001010, DATA_to_enc, sig_acc};
      end
    end
  end

  // Sample accumulators. A group that opens (from EMPTY or a type change)
  // overwrites the accumulator so stale fields never leak into a word.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      base_acc <= 24'h0;
      sig_acc  <= 13'h0;
    end else if (enable) begin
      if (baseline_flag) begin
        if (state != BASE_ACC) begin
          base_acc <= {18'h0, DATA_to_enc[5:0]};
        end else begin
          case (cnt)
            3'd1:    base_acc[11:6]  <= DATA_to_enc[5:0];
            3'd2:    base_acc[17:12] <= DATA_to_enc[5:0];
            3'd3:    base_acc[23:18] <= DATA_to_enc[5:0];
            default: base_acc        <= base_acc;
          endcase
        end
      end else if (state != SIG_ACC) begin
        sig_acc <= DATA_to_enc;
      end
    end
  end

  // Buffer control. The level MSB is set only when the buffer holds exactly
  // FifoDepth words, so it doubles as the full flag. A push into a full
  // buffer survives only if the head is popped on the same edge.
  assign full      = fifo_level[NBitsCnt];
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = push_req & (~full | pop);
  assign out_data  = out_valid ? mem[rd_ptr] : 32'h0;

  // Word storage; contents are only visible through out_data when valid,
  // so the array itself needs no reset.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Pointers, level and sticky overflow.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PtrOne;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrOne;
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LvlOne;
        2'b01:   fifo_level <= fifo_level - LvlOne;
        default: fifo_level <= fifo_level;
      endcase
      if (push_req & full & ~pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ldtu_sample_packer.sv
// tb_ldtu_sample_packer
// Directed and randomized bench for ldtu_sample_packer. A reference model
// groups samples in a queue and builds words from the grouping rules, and a
// second queue stands in for the output buffer.
module tb_ldtu_sample_packer;

  localparam int Depth = 8;

  logic        CLK;
  logic        reset;
  logic        enable;
  logic [12:0] DATA_to_enc;
  logic        baseline_flag;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_level;
  logic        overflow;

  int n_tests;
  int n_fail;

  // Reference model state.
  logic [12:0] grp[$];
  bit          grp_base;
  logic [31:0] exp_q[$];
  bit          m_ovf;

  ldtu_sample_packer #(.FifoDepth(8), .NBitsCnt(3)) dut (
    .CLK(CLK),
    .reset(reset),
    .enable(enable),
    .DATA_to_enc(DATA_to_enc),
    .baseline_flag(baseline_flag),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fifo_level(fifo_level),
    .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Builds the word for the currently open group from its sample list.
  function automatic logic [31:0] build_word();
    logic [29:0] f;
    logic [31:0] w;
    f = '0;
    if (grp_base) begin
      for (int i = 0; i < grp.size(); i++) begin
        f = f | ({24'h0, grp[i][5:0]} << (6 * i));
      end
      if (grp.size() == 5) w = {2'b01, f};
      else                 w = {4'hE, 4'(grp.size()), f[23:0]};
    end else begin
      if (grp.size() == 2) w = {6'b001010, grp[1], grp[0]};
      else                 w = {6'b001011, 13'h0, grp[0]};
    end
    return w;
  endfunction

  // One clock edge of the reference behaviour.
  task automatic model_step(input bit en, input bit base, input logic [12:0] d, input bit rdy);
    logic [31:0] w;
    bit have;
    have = 0;
    w = '0;
    if (en) begin
      if (grp.size() == 0) begin
        grp_base = base;
        grp.push_back(d);
      end else if (base == grp_base) begin
        grp.push_back(d);
        if ((base && grp.size() == 5) || (!base && grp.size() == 2)) begin
          w = build_word();
          have = 1;
          grp.delete();
        end
      end else begin
        w = build_word();
        have = 1;
        grp.delete();
        grp_base = base;
        grp.push_back(d);
      end
    end else if (grp.size() != 0) begin
      w = build_word();
      have = 1;
      grp.delete();
    end
    if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (have) begin
      if (exp_q.size() < Depth) exp_q.push_back(w);
      else m_ovf = 1;
    end
  endtask

  task automatic model_reset();
    grp.delete();
    exp_q.delete();
    m_ovf = 0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compares every output against the model.
  task automatic check_all(input string tag);
    logic [31:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    check_output({tag, ".valid"}, {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
    check_output({tag, ".data"}, out_data, head);
    check_output({tag, ".level"}, {28'h0, fifo_level}, 32'(exp_q.size()));
    check_output({tag, ".ovf"}, {31'h0, overflow}, {31'h0, m_ovf});
  endtask

  // Drives one cycle of inputs at the falling edge, applies the model at the
  // rising edge and checks at the next falling edge.
  task automatic apply_stimulus(input bit en, input bit base, input logic [12:0] d, input bit rdy);
    enable        = en;
    baseline_flag = base;
    DATA_to_enc   = d;
    out_ready     = rdy;
    @(posedge CLK);
    model_step(en, base, d, rdy);
    @(negedge CLK);
    check_all("step");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    enable = 0; baseline_flag = 0; DATA_to_enc = '0; out_ready = 0;
    model_reset();
    grp_base = 0;
    reset = 1'b0;
    #3;
    check_all("reset");
    @(negedge CLK);
    reset = 1'b1;

    // Five baseline samples make one full word.
    for (int i = 1; i <= 5; i++) apply_stimulus(1, 1, 13'(i), 1);
    check_output("base_full", out_data, 32'h45103081);
    apply_stimulus(0, 0, 13'h0, 1);
    check_output("base_full_gone", {31'h0, out_valid}, 32'h0);

    // Signal pair, then a baseline sample opening a new group.
    apply_stimulus(1, 0, 13'h1ABC, 1);
    apply_stimulus(1, 0, 13'h0123, 1);
    check_output("sig_pair", out_data, 32'h28247ABC);
    apply_stimulus(1, 1, 13'h003F, 1);
    apply_stimulus(0, 0, 13'h0, 1);
    check_output("base_one", out_data, 32'hE100003F);
    apply_stimulus(0, 0, 13'h0, 1);

    // Partial baseline then single signal flushed by enable low.
    for (int i = 1; i <= 3; i++) apply_stimulus(1, 1, 13'(i), 0);
    apply_stimulus(1, 0, 13'h1000, 0);
    apply_stimulus(0, 0, 13'h0, 0);
    check_output("part_head", out_data, 32'hE3003081);
    check_output("part_level", {28'h0, fifo_level}, 32'd2);
    apply_stimulus(0, 0, 13'h0, 1);
    check_output("single_head", out_data, 32'h2C001000);
    apply_stimulus(0, 0, 13'h0, 1);

    // Nine signal words into a stalled buffer, then drain.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1, 0, 13'($urandom), 0);
      apply_stimulus(1, 0, 13'($urandom), 0);
    end
    check_output("ovf_level", {28'h0, fifo_level}, 32'd8);
    check_output("ovf_flag", {31'h0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 13'h0, 1);
    check_output("drained", {28'h0, fifo_level}, 32'd0);

    // Full buffer with push and pop on the same edge.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, 0, 13'($urandom), 0);
      apply_stimulus(1, 0, 13'($urandom), 0);
    end
    apply_stimulus(1, 0, 13'h0AAA, 0);
    apply_stimulus(1, 0, 13'h1555, 1);
    check_output("full_pp_level", {28'h0, fifo_level}, 32'd8);
    check_output("full_pp_ovf", {31'h0, overflow}, 32'd0);
    for (int i = 0; i < 9; i++) apply_stimulus(0, 0, 13'h0, 1);

    // Reset in the middle of a baseline group with words buffered.
    apply_stimulus(1, 0, 13'h0111, 0);
    apply_stimulus(1, 0, 13'h0222, 0);
    for (int i = 1; i <= 3; i++) apply_stimulus(1, 1, 13'(i + 8), 0);
    enable = 0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge CLK);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 13'h0, 1);
    check_output("no_partial", {31'h0, out_valid}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 9) != 0, 1'($urandom), 13'($urandom),
                     $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
